// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - SD SPI-mode frame constants, framer states and command indices
package sd_spi_pkg;

  // SD command frame layout: start pattern, index, 4 argument bytes, CRC7 plus end bit
  localparam logic [1:0] SD_START_BITS = 2'b01;
  localparam int         SD_FRAME_LEN  = 6;
  localparam logic       SD_END_BIT    = 1'b1;

  typedef enum logic [1:0] {
    FR_IDLE = 2'd0,
    FR_ARG  = 2'd1,
    FR_CRC  = 2'd2
  } frame_state_t;

  // Command indices shared with responder logic
  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  // True for the commands the responder is expected to handle
  function automatic logic sd_cmd_known(input logic [5:0] idx);
    return (idx == CMD0) || (idx == CMD8) || (idx == CMD17) ||
           (idx == CMD55) || (idx == ACMD41);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-flop synchronizer with registered rise/fall detect
module spi_sync_edge #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [N-1:0] chain;
  logic         prev;

  assign sync_out = chain[N-1];

  // Shift the pin through the chain and flag level changes of the last stage
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      chain <= {N{RESET_VAL}};
      prev  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[N-2:0], din};
      prev  <= chain[N-1];
      rise  <= chain[N-1] & ~prev;
      fall  <= ~chain[N-1] & prev;
    end
  end

endmodule

// File: rtl/sd_spi_target.sv
// rtl/sd_spi_target.sv - SPI mode-0 target emulating the SD card side with command framing
module sd_spi_target
  import sd_spi_pkg::*;
#(
  parameter logic [7:0] IDLE_FILL   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        spi_cs,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [7:0]  rx_byte,
  output logic        rx_strobe,
  input  logic [7:0]  tx_byte,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic        tx_underrun,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc
);

  localparam logic [1:0] ARG_LAST = 2'(SD_FRAME_LEN - 3);

  logic cs_s, cs_fall, cs_rise_unused;
  logic sclk_rise, sclk_sync_unused, sclk_fall_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clock(clock), .reset_n(reset_n), .din(spi_cs),
    .sync_out(cs_s), .rise(cs_rise_unused), .fall(cs_fall)
  );

  spi_sync_edge #(.N(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clock(clock), .reset_n(reset_n), .din(spi_sclk),
    .sync_out(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  spi_sync_edge #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_mosi_sync (
    .clock(clock), .reset_n(reset_n), .din(spi_mosi),
    .sync_out(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] tx_buf;
  logic       shift_pending;

  // Byte engine: rx/tx shifters, bit counter and the one-entry tx buffer
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      spi_miso      <= 1'b1;
      rx_byte       <= 8'h00;
      rx_strobe     <= 1'b0;
      tx_ready      <= 1'b1;
      tx_underrun   <= 1'b0;
      bit_cnt       <= 3'd0;
      rx_shift      <= 7'd0;
      tx_shift      <= IDLE_FILL;
      tx_buf        <= 8'h00;
      shift_pending <= 1'b0;
    end else begin
      rx_strobe     <= 1'b0;
      shift_pending <= 1'b0;
      if (tx_load && tx_ready) begin
        tx_buf      <= tx_byte;
        tx_ready    <= 1'b0;
        tx_underrun <= 1'b0;
      end
      if (cs_s) begin
        bit_cnt  <= 3'd0;
        spi_miso <= 1'b1;
      end else begin
        spi_miso <= tx_shift[7];
        if (cs_fall || (sclk_rise && bit_cnt == 3'd7)) begin
          // Reload decisions use the buffer state from before this cycle
          if (!tx_ready) begin
            tx_shift <= tx_buf;
            tx_ready <= 1'b1;
          end else begin
            tx_shift    <= IDLE_FILL;
            tx_underrun <= 1'b1;
          end
        end
        if (sclk_rise) begin
          rx_shift <= {rx_shift[5:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_byte   <= {rx_shift, mosi_s};
            rx_strobe <= 1'b1;
          end else begin
            shift_pending <= 1'b1;
          end
        end else if (shift_pending) begin
          // Advance MISO only after the master has sampled the current bit
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  frame_state_t fr_state;
  logic [1:0]   arg_cnt;

  // Command framer: index byte, four argument bytes, CRC/end-bit byte
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fr_state  <= FR_IDLE;
      arg_cnt   <= 2'd0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_index <= 6'd0;
      cmd_arg   <= 32'd0;
      cmd_crc   <= 7'd0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (cs_s) begin
        fr_state <= FR_IDLE;
      end else if (rx_strobe) begin
        case (fr_state)
          FR_IDLE: begin
            if (rx_byte[7:6] == SD_START_BITS) begin
              cmd_index <= rx_byte[5:0];
              arg_cnt   <= 2'd0;
              fr_state  <= FR_ARG;
            end
          end
          FR_ARG: begin
            cmd_arg <= {cmd_arg[23:0], rx_byte};
            arg_cnt <= arg_cnt + 2'd1;
            if (arg_cnt == ARG_LAST) fr_state <= FR_CRC;
          end
          FR_CRC: begin
            cmd_crc  <= rx_byte[7:1];
            cmd_valid <= (rx_byte[0] == SD_END_BIT);
            cmd_err   <= (rx_byte[0] != SD_END_BIT);
            fr_state <= FR_IDLE;
          end
          default: fr_state <= FR_IDLE;
        endcase
      end
    end
  end

endmodule
